// File: rtl/psum_acc_quant_if.sv
// Stream bundle between the PE column, the partial-sum accumulator/quantizer
// and the output buffer writer.
//
// Signals:
//   psum_valid / psum_ready  partial-sum handshake (upstream -> block)
//   psum_in                  signed 32-bit partial sum
//   psum_first / psum_last   pass markers travelling with the partial sum
//   bias / shift / relu_en   quantization controls, used with a last-pass psum
//   out_valid / out_ready    int8 result handshake (block -> output writer)
//   out_data                 signed int8 result at the FIFO head
//
// Modports:
//   master  the side that produces partial sums and consumes results
//   slave   the accumulator/quantizer block itself
interface psum_acc_quant_if;
    logic               psum_valid;
    logic               psum_ready;
    logic signed [31:0] psum_in;
    logic               psum_first;
    logic               psum_last;
    logic signed [31:0] bias;
    logic        [4:0]  shift;
    logic               relu_en;
    logic               out_valid;
    logic               out_ready;
    logic        [7:0]  out_data;

    modport master (
        output psum_valid, psum_in, psum_first, psum_last,
        output bias, shift, relu_en, out_ready,
        input  psum_ready, out_valid, out_data
    );

    modport slave (
        input  psum_valid, psum_in, psum_first, psum_last,
        input  bias, shift, relu_en, out_ready,
        output psum_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_acc_quant.sv
// Partial-sum accumulator and int8 quantizer behind a PE systolic column.
//
// Partial sums are accumulated per output position across input-channel
// passes. On a last-pass partial sum the finished sum goes through bias add,
// round-half-up arithmetic right shift, optional ReLU and int8 clipping, and
// the result is queued in a first-word-fall-through output FIFO.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active low
//   clr        synchronous clear of index, pipeline, FIFO and sat_flag
//   bus        psum_acc_quant_if.slave stream bundle (see interface file)
//   pass_done  one-cycle pulse after the last accumulator entry is written
//   sat_flag   sticky flag, set by any 32-bit saturation
module psum_acc_quant #(
    parameter int N_ACC      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    psum_acc_quant_if.slave bus,
    output logic            pass_done,
    output logic            sat_flag
);

    localparam int IW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold FIFO count plus the two in-flight pipeline items.
    localparam int CW = PW + 2;

    localparam logic [IW-1:0]      IDX_LAST = IW'(N_ACC - 1);
    localparam logic [CW-1:0]      DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic signed [31:0] MAX32    = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MIN32    = 32'sh8000_0000;

    logic [IW-1:0]      idx;
    logic signed [31:0] acc [N_ACC];

    logic               s1_valid;
    logic signed [31:0] s1_sum;
    logic signed [31:0] s1_bias;
    logic [4:0]         s1_shift;
    logic               s1_relu;

    logic               s2_valid;
    logic [7:0]         s2_data;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    logic [CW-1:0]      pend;
    logic               accept;
    logic               push;
    logic               pop;

    // Readiness looks only at registered state, so every accepted last-pass
    // item already owns a FIFO slot by the time it reaches the push point.
    assign pend           = CW'(s1_valid) + CW'(s2_valid);
    assign bus.psum_ready = (count + pend) < DEPTH_C;
    assign accept         = bus.psum_valid && bus.psum_ready && !clr;

    // Stage-1 arithmetic: overwrite on first pass, otherwise saturating add.
    logic signed [31:0] acc_cur;
    logic        [32:0] acc_sum33;
    logic               acc_ovf;
    logic signed [31:0] acc_new;
    logic               acc_sat_hit;

    assign acc_cur   = acc[idx];
    assign acc_sum33 = {acc_cur[31], acc_cur} + {bus.psum_in[31], bus.psum_in};
    assign acc_ovf   = acc_sum33[32] ^ acc_sum33[31];

    always_comb begin
        acc_new     = bus.psum_in;
        acc_sat_hit = 1'b0;
        if (!bus.psum_first) begin
            if (acc_ovf) begin
                acc_new     = acc_sum33[32] ? MIN32 : MAX32;
                acc_sat_hit = 1'b1;
            end else begin
                acc_new = acc_sum33[31:0];
            end
        end
    end

    // Stage-2 arithmetic: saturating bias add, then rounding shift in 33 bits
    // so the rounding constant can never overflow the biased value.
    logic        [32:0] bias_sum33;
    logic               bias_ovf;
    logic signed [31:0] v_biased;
    logic        [4:0]  shift_m1;
    logic        [32:0] round_bit;
    logic signed [32:0] v_ext;
    logic signed [32:0] v_round;
    logic signed [32:0] v_shifted;
    logic signed [32:0] v_relu;
    logic        [7:0]  q_data;

    assign bias_sum33 = {s1_sum[31], s1_sum} + {s1_bias[31], s1_bias};
    assign bias_ovf   = bias_sum33[32] ^ bias_sum33[31];
    assign v_biased   = bias_ovf ? (bias_sum33[32] ? MIN32 : MAX32) : bias_sum33[31:0];
    assign shift_m1   = s1_shift - 5'd1;
    assign round_bit  = 33'd1 << shift_m1;
    assign v_ext      = {v_biased[31], v_biased};
    assign v_round    = v_ext + $signed(round_bit);
    assign v_shifted  = (s1_shift == 5'd0) ? v_ext : (v_round >>> s1_shift);

    always_comb begin
        v_relu = v_shifted;
        if (s1_relu && v_shifted[32]) begin
            v_relu = '0;
        end
        if (v_relu > 33'sd127) begin
            q_data = 8'h7F;
        end else if (v_relu < -33'sd128) begin
            q_data = 8'h80;
        end else begin
            q_data = v_relu[7:0];
        end
    end

    // Accumulator bank and position index. clr rewinds the index but keeps
    // the stored sums, so the following pass is expected to start with
    // psum_first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ACC; i++) begin
                acc[i] <= '0;
            end
            idx       <= '0;
            pass_done <= 1'b0;
        end else if (clr) begin
            idx       <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= accept && (idx == IDX_LAST);
            if (accept) begin
                acc[idx] <= acc_new;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Two-stage quantize pipeline and the sticky saturation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_bias  <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            sat_flag <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            s1_valid <= accept && bus.psum_last;
            if (accept && bus.psum_last) begin
                s1_sum   <= acc_new;
                s1_bias  <= bus.bias;
                s1_shift <= bus.shift;
                s1_relu  <= bus.relu_en;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= q_data;
            end
            if ((accept && acc_sat_hit) || (s1_valid && bias_ovf)) begin
                sat_flag <= 1'b1;
            end
        end
    end

    // Output FIFO. A push never finds it full without a matching pop, because
    // of the reservation made by psum_ready.
    assign push = s2_valid;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= s2_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = fifo_mem[rd_ptr];

endmodule
